// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, lane count and wait-counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 4;

  function automatic logic [BYTES_PER_WORD-1:0] full_mask();
    return '1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write mask.
// Reads are registered; a write and a read never share a cycle.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [AW-1:0]             i_addr,
  input  logic [DATA_W-1:0]         i_wdata,
  input  logic [BYTES_PER_WORD-1:0] i_be,
  output logic [DATA_W-1:0]         o_rdata
);

  localparam int LW = DATA_W / BYTES_PER_WORD;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
          if (i_be[b]) begin
            r_mem[i_addr][b*LW +: LW] <= i_wdata[b*LW +: LW];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states.
// Build with DMEM_BYTE_STROBE_EN to add the req_be byte-strobe port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [31:0]               req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [BYTES_PER_WORD-1:0] req_be,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic                      r_we;
  logic                      r_err;
  logic [AW-1:0]             r_idx;
  logic [DATA_W-1:0]         r_wdata;
  logic [BYTES_PER_WORD-1:0] r_be;

  logic                      w_accept;
  logic                      w_commit;
  logic                      w_addr_err;
  logic                      w_arr_en;
  logic [BYTES_PER_WORD-1:0] w_be_in;
  logic [DATA_W-1:0]         w_arr_q;

`ifdef DMEM_BYTE_STROBE_EN
  assign w_be_in = req_be;
`else
  assign w_be_in = full_mask();
`endif

  assign w_addr_err = (req_addr[1:0] != 2'b00)
                    || (req_addr[31:AW+2] != '0);

  // Every request passes through WAIT so latency is WAIT_CYCLES+1
  // edges even when WAIT_CYCLES is 0.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
    w_commit  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept  = 1'b1;
          w_next    = WAIT;
          w_cnt_nxt = '0;
        end
      end
      WAIT: begin
        if (r_cnt == LAST) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next    = IDLE;
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_we    <= req_we;
      r_err   <= w_addr_err;
      r_idx   <= req_addr[AW+1:2];
      r_wdata <= req_wdata;
      r_be    <= w_be_in;
    end
  end

  // Reset on the commit edge cancels the access.
  assign w_arr_en = w_commit && !rst && !r_err;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_arr_en),
    .i_we    (r_we),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_arr_q)
  );

  assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_arr_q : '0;
  assign rsp_err   = rsp_valid && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, corner sequences, random vs model.
// Honours DMEM_BYTE_STROBE_EN for the byte-strobe cases.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_valid, b_valid;
  logic        req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be;
`endif
  logic        a_ready, a_rvalid, a_err;
  logic        b_ready, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mem_m [256];

  dmem_responder #(
    .DATA_W(32), .DEPTH(256), .AW(8), .WAIT_CYCLES(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .rsp_valid(a_rvalid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  dmem_responder #(
    .DATA_W(32), .DEPTH(256), .AW(8), .WAIT_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .rsp_valid(b_rvalid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          hold;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic f_ready(input bit s);
    return s ? b_ready : a_ready;
  endfunction
  function automatic logic f_rvalid(input bit s);
    return s ? b_rvalid : a_rvalid;
  endfunction
  function automatic logic [31:0] f_rdata(input bit s);
    return s ? b_rdata : a_rdata;
  endfunction
  function automatic logic f_err(input bit s);
    return s ? b_err : a_err;
  endfunction

  // Reference behaviour of the WAIT_CYCLES=2 instance's storage.
  function automatic void model(input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [3:0] be,
                                output logic [31:0] rd, output logic er);
    logic [3:0] eff;
    int idx;
    eff = be;
`ifndef DMEM_BYTE_STROBE_EN
    eff = 4'hF;
`endif
    er  = (addr % 4 != 0) || (addr >= 32'd1024);
    rd  = '0;
    idx = int'(addr / 4) % 256;
    if (!er) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (eff[b]) mem_m[idx][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        rd = mem_m[idx];
      end
    end
  endfunction

  task automatic txn(input bit s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int hold,
                     output logic [31:0] rd, output logic er);
    int lat;
    int exp_lat;
    exp_lat = s ? 1 : 3;
    @(negedge clk);
    check("req_ready_idle", {31'b0, f_ready(s)}, 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
`ifdef DMEM_BYTE_STROBE_EN
    req_be    = be;
`else
    if (be == 4'hx) req_we = we;
`endif
    rsp_ready = (hold == 0);
    if (s) b_valid = 1'b1;
    else a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    check("req_ready_busy", {31'b0, f_ready(s)}, 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!f_rvalid(s) && lat < 40);
    check("latency", lat, exp_lat);
    rd = f_rdata(s);
    er = f_err(s);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_stable",
            {29'b0, f_rvalid(s), f_ready(s), f_rdata(s) == rd}, 32'b101);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_drop_ready_back",
          {30'b0, f_rvalid(s), f_ready(s)}, 32'b01);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, exp_rd, addr, wd;
    logic        er, exp_er, we;
    logic [3:0]  be;
    int          hold, r, n, idx;

    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    rsp_ready = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h10;
    req_wdata = '0;
`ifdef DMEM_BYTE_STROBE_EN
    req_be = 4'hF;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {a_ready, a_rvalid, a_err, a_rdata != 0}, 4'b1000);
    check("reset_b", {b_ready, b_rvalid, b_err, b_rdata != 0}, 4'b1000);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 32'hDEAD_BEEF, 1'b0};
    tbl[3] = '{1'b0, 32'h0000_0012, 32'h0,         4'hF, 0, 32'h0, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0400, 32'h1111_1111, 4'hF, 0, 32'h0, 1'b1};
    tbl[6] = '{1'b0, 32'h0000_0000, 32'h0,         4'hF, 2, 32'hCAFE_F00D, 1'b0};
    tbl[7] = '{1'b1, 32'h8000_0000, 32'h2222_2222, 4'hF, 0, 32'h0, 1'b1};
    tbl[8] = '{1'b1, 32'h0000_03FC, 32'h55AA_55AA, 4'hF, 1, 32'h0, 1'b0};
    tbl[9] = '{1'b0, 32'h0000_03FC, 32'h0,         4'hF, 0, 32'h55AA_55AA, 1'b0};

    for (int i = 0; i < 10; i++) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].be, exp_rd, exp_er);
      txn(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].be,
          tbl[i].hold, rd, er);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      check($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
    end

    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b1, 32'(i * 4), wd, 4'hF, exp_rd, exp_er);
      txn(1'b0, 1'b1, 32'(i * 4), wd, 4'hF, 0, rd, er);
    end

    // Reset in the first WAIT cycle: the store must vanish.
    @(negedge clk);
    req_we = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h1234_5678;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_wait_outs", {a_ready, a_rvalid, a_err, a_rdata != 0}, 4'b1000);
    n = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (a_rvalid) n++;
    end
    check("rst_wait_no_rsp", n, 0);
    model(1'b0, 32'h20, 32'h0, 4'hF, exp_rd, exp_er);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    check("rst_wait_load", rd, exp_rd);

    // Reset while in RESP: the store has already committed.
    @(negedge clk);
    req_we = 1'b1;
    req_addr = 32'h24;
    req_wdata = 32'h0F0F_1234;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    n = 0;
    while (!a_rvalid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_resp_reached", {31'b0, a_rvalid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_resp_outs", {a_ready, a_rvalid, a_err, a_rdata != 0}, 4'b1000);
    model(1'b1, 32'h24, 32'h0F0F_1234, 4'hF, exp_rd, exp_er);
    txn(1'b0, 1'b0, 32'h24, 32'h0, 4'hF, 0, rd, er);
    check("rst_resp_load", rd, 32'h0F0F_1234);

`ifdef DMEM_BYTE_STROBE_EN
    model(1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, exp_rd, exp_er);
    txn(1'b0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, 0, rd, er);
    model(1'b1, 32'h30, 32'h1122_3344, 4'b0101, exp_rd, exp_er);
    txn(1'b0, 1'b1, 32'h30, 32'h1122_3344, 4'b0101, 0, rd, er);
    txn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    check("be_merge", rd, 32'hAA22_CC44);
    txn(1'b0, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0000, 0, rd, er);
    check("be_zero_err", {31'b0, er}, 32'd0);
    txn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    check("be_zero_noop", rd, 32'hAA22_CC44);
`endif

    // Zero-wait instance: stores, then back-to-back loads.
    txn(1'b1, 1'b1, 32'h10, 32'h0A0A_0A0A, 4'hF, 0, rd, er);
    txn(1'b1, 1'b1, 32'h14, 32'h0B0B_0B0B, 4'hF, 0, rd, er);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("w0_load10", rd, 32'h0A0A_0A0A);
    txn(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, 0, rd, er);
    check("w0_load14", rd, 32'h0B0B_0B0B);
    txn(1'b1, 1'b0, 32'h15, 32'h0, 4'hF, 1, rd, er);
    check("w0_misaligned", {er, rd != 0}, 2'b10);

    for (int i = 0; i < 150; i++) begin
      r    = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      addr = 32'(idx * 4);
      if (r == 8) addr = addr + 32'($urandom_range(1, 3));
      if (r == 9) addr = addr | (32'h400 << $urandom_range(0, 21));
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      be   = 4'($urandom);
      hold = $urandom_range(0, 2);
      model(we, addr, wd, be, exp_rd, exp_er);
      txn(1'b0, we, addr, wd, be, hold, rd, er);
      check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      check($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, exp_er});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the processor's data-memory port: accepts one load/store request per handshake, inserts a programmable number of wait states, and returns read data and a status flag.
- Replaces the zero-latency combinational data memory so the datapath and a future stall unit can be exercised against realistic memory timing.
- Sits between the load/store datapath (the initiator) and a word-organised storage array.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 256, number of words stored.
- AW, 8, word-index width; must equal clog2(DEPTH).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  the initiator presents a request.
- req_ready  out  1  the responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data.
- req_be  in  4  byte strobes; present only when DMEM_BYTE_STROBE_EN is defined.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  the initiator accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  the request was misaligned or out of range.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage contents are not cleared.
- States:
  - IDLE: req_ready=1. When req_valid is high, latch we, addr, wdata (and be). Go to WAIT if WAIT_CYCLES>0, otherwise go directly to RESP.
  - WAIT: req_ready=0. The counter counts 1..WAIT_CYCLES; on reaching WAIT_CYCLES, go to RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready is high. On rsp_valid and rsp_ready, go to IDLE; rsp_valid drops on the next edge.
- Commit point: the storage access happens on the edge that enters RESP.
  - A store writes the array on that edge.
  - A load captures the array word into rsp_rdata on that edge.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
- Throughput: one outstanding request, no overlap. req_ready is low from acceptance until the response handshake completes. A back-to-back request is accepted no earlier than the cycle after the response handshake.
- Address decode:
  - Word index = req_addr[AW+1:2].
  - Error when req_addr[1:0]!=0 or req_addr[31:AW+2]!=0.
  - On error: no write, rsp_rdata=0, rsp_err=1. Latency is identical to a normal access.
- Read-after-write: a load accepted after a store's response sees the stored data.
- Initiator signals other than req_valid are don't-care outside IDLE.
- Reset during WAIT or RESP: the transaction is discarded and no response is produced. A store interrupted in WAIT never commits; a store already in RESP has already committed.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - The req_be port exists; a store writes only the bytes whose strobe is 1.
  - req_be=0 on a store is a legal no-op with rsp_err=0.
  - Loads ignore req_be and return the full word.
- Undefined:
  - No req_be port; every store writes the full word.

Decomposition:
- Shared package dmem_pkg:
  - State encoding (IDLE, WAIT, RESP).
  - Constant BYTES_PER_WORD=4.
  - Wait-counter width constant (4).
- Sub-module dmem_array: synchronous word RAM with a write enable, per-byte write mask (all-ones when the macro is off) and registered read. The FSM and decode stay in dmem_responder.

Test Plan:
- Store then load, WAIT_CYCLES=2:
  - Store 0x0000_0010 <- 0xDEAD_BEEF: rsp_valid rises 3 edges after acceptance, rsp_err=0, rsp_rdata=0.
  - Load 0x10: returns 0xDEAD_BEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load of 0x10 -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; release -> IDLE one edge later, req_ready=1.
- Errors:
  - Load 0x0000_0012 (misaligned) -> rsp_err=1, rsp_rdata=0.
  - Store to 0x0000_0400 (DEPTH=256, out of range) -> rsp_err=1; a subsequent load of 0x0 returns the unchanged word.
- WAIT_CYCLES=0: load accepted at edge N -> rsp_valid high after edge N+1; back-to-back loads of 0x10 and 0x14 each complete in 2 cycles with rsp_ready held at 1.
- Reset mid-operation: store 0x20 <- 0x1234_5678, assert rst in the first WAIT cycle -> no response, outputs at reset values; a later load of 0x20 returns the prior contents.
- Byte strobes (DMEM_BYTE_STROBE_EN defined): word 0x30=0xAABB_CCDD, store 0x1122_3344 with be=4'b0101 -> load of 0x30 returns 0xAA22_CC44.
